// File: rtl/smg_pkg.sv
// Shared seven-segment definitions: active-high gfedcba glyphs and a width helper.
// Output polarity is applied by the consumer, never here.
package smg_pkg;

  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // ceil(log2(n)), never below 1 so single-entry counters still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/smg_decoder.sv
// 4-bit hex to active-high 7-segment (gfedcba) decoder, purely combinational.
module smg_decoder
  import smg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  assign o_seg = hex_glyph(i_nib);

endmodule

// File: rtl/smg_scan_ctrl.sv
// Seven-segment controller: nibble store, leading-zero blanking, static and
// time-multiplexed scan outputs, and an update-indicator flash timer.
module smg_scan_ctrl
  import smg_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 50000,
  parameter int FLASH_CYC   = 25000000,
  parameter int NIB_ORDER   = 1,
  parameter int SEG_ACT_LOW = 1,
  parameter int DIG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic                  data_vld,
  input  logic                  hold,
  input  logic                  blank_lz,
  input  logic                  scan_mode,
  output logic [7*DIGITS-1:0]   seg_static,
  output logic [6:0]            seg_scan,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  new_data
);

  localparam int IDX_W = clog2(DIGITS);
  localparam int PRE_W = clog2(SCAN_DIV);
  localparam int FL_W  = clog2(FLASH_CYC + 1);
  localparam logic [6:0]        SEG_INV = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_INV = (DIG_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic                     w_acc;
  logic [DIGITS-1:0][3:0]   w_nib_in;
  logic [DIGITS-1:0][3:0]   r_nib_p0;
  logic [DIGITS-1:0][6:0]   w_glyph;
  logic [DIGITS-1:0]        w_blank;
  logic                     w_lead_zero;
  logic [DIGITS-1:0][6:0]   r_seg_static_p1;
  logic [6:0]               w_scan_glyph;
  logic [6:0]               r_seg_scan_p1;
  logic [DIGITS-1:0]        r_dig_sel_p1;
  logic                     r_scan_d;
  logic [PRE_W-1:0]         r_pre;
  logic [PRE_W-1:0]         w_pre_nxt;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_idx_nxt;
  logic [FL_W-1:0]          r_flash;

  assign w_acc = data_vld & ~hold;

  // IR order pairs digits by byte, most significant byte on the lowest digit pair.
  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    if (NIB_ORDER != 0) begin : g_ir
      localparam int BASE = 8 * (DIGITS / 2 - 1 - d / 2) + 4 * (d % 2);
      assign w_nib_in[d] = data_in[BASE +: 4];
    end else begin : g_lin
      assign w_nib_in[d] = data_in[4 * d +: 4];
    end
    smg_decoder u_dec (
      .i_nib (r_nib_p0[d]),
      .o_seg (w_glyph[d])
    );
  end

  // ---- stage p0: nibble store ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nib_p0 <= '0;
    end else if (w_acc) begin
      r_nib_p0 <= w_nib_in;
    end
  end

  always_comb begin
    w_blank     = '0;
    w_lead_zero = 1'b1;
    for (int d = DIGITS - 1; d > 0; d--) begin
      w_lead_zero = w_lead_zero & (r_nib_p0[d] == 4'h0);
      w_blank[d]  = blank_lz & w_lead_zero;
    end
  end

  // Prescaler and index; a scan_mode change in either direction restarts both.
  always_comb begin
    w_pre_nxt = r_pre + 1'b1;
    w_idx_nxt = r_idx;
    if (scan_mode != r_scan_d) begin
      w_pre_nxt = '0;
      w_idx_nxt = '0;
    end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
      w_pre_nxt = '0;
      w_idx_nxt = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end
  end

  smg_decoder u_dec_scan (
    .i_nib (r_nib_p0[w_idx_nxt]),
    .o_seg (w_scan_glyph)
  );

  // ---- stage p1: registered display outputs ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_static_p1 <= {DIGITS{SEG_ZERO ^ SEG_INV}};
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        r_seg_static_p1[d] <= (w_blank[d] ? SEG_OFF : w_glyph[d]) ^ SEG_INV;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre         <= '0;
      r_idx         <= '0;
      r_scan_d      <= 1'b0;
      r_dig_sel_p1  <= DIGITS'(1) ^ DIG_INV;
      r_seg_scan_p1 <= SEG_ZERO ^ SEG_INV;
    end else begin
      r_pre    <= w_pre_nxt;
      r_idx    <= w_idx_nxt;
      r_scan_d <= scan_mode;
      if (scan_mode) begin
        r_dig_sel_p1  <= (DIGITS'(1) << w_idx_nxt) ^ DIG_INV;
        r_seg_scan_p1 <= (w_blank[w_idx_nxt] ? SEG_OFF : w_scan_glyph) ^ SEG_INV;
      end else begin
        r_dig_sel_p1  <= ~DIG_INV;
        r_seg_scan_p1 <= SEG_OFF ^ SEG_INV;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_flash <= '0;
    end else if (w_acc) begin
      r_flash <= FL_W'(FLASH_CYC);
    end else if (r_flash != '0) begin
      r_flash <= r_flash - 1'b1;
    end
  end

  assign seg_static = r_seg_static_p1;
  assign seg_scan   = r_seg_scan_p1;
  assign dig_sel    = r_dig_sel_p1;
  assign new_data   = (r_flash != '0);

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Directed bench for smg_scan_ctrl: IR-order and linear-order instances share stimulus.
`timescale 1ns/1ps
module tb_smg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_vld;
  logic        hold;
  logic        blank_lz;
  logic        scan_mode;
  logic [55:0] seg_static;
  logic [6:0]  seg_scan;
  logic [7:0]  dig_sel;
  logic        new_data;
  logic [55:0] seg_static_lin;
  logic [6:0]  seg_scan_lin;
  logic [7:0]  dig_sel_lin;
  logic        new_data_lin;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [6:0] GLY [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  smg_scan_ctrl #(
    .DIGITS(8), .SCAN_DIV(4), .FLASH_CYC(10), .NIB_ORDER(1), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld), .hold(hold),
    .blank_lz(blank_lz), .scan_mode(scan_mode), .seg_static(seg_static),
    .seg_scan(seg_scan), .dig_sel(dig_sel), .new_data(new_data)
  );

  smg_scan_ctrl #(
    .DIGITS(8), .SCAN_DIV(4), .FLASH_CYC(10), .NIB_ORDER(0), .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)
  ) u_dut_lin (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_vld(data_vld), .hold(hold),
    .blank_lz(blank_lz), .scan_mode(scan_mode), .seg_static(seg_static_lin),
    .seg_scan(seg_scan_lin), .dig_sel(dig_sel_lin), .new_data(new_data_lin)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] val);
    data_in  = val;
    data_vld = 1'b1;
    tick();
    data_vld = 1'b0;
  endtask

  function automatic logic [6:0] dsg(input logic [55:0] v, input int d);
    return v[7 * d +: 7];
  endfunction

  initial begin
    logic [55:0] e_zero;
    logic [55:0] e_ir;
    logic [7:0]  exp_sel;
    int          cnt;

    rst_n = 1'b0; data_in = '0; data_vld = 1'b0; hold = 1'b0;
    blank_lz = 1'b0; scan_mode = 1'b0;
    e_zero = {8{7'h40}};
    // 12345678 in IR order: digit0..7 = 2,1,4,3,6,5,8,7
    e_ir = {GLY[7], GLY[8], GLY[5], GLY[6], GLY[3], GLY[4], GLY[1], GLY[2]};

    tick(); tick();
    chk("rst_static", seg_static, e_zero);
    chk("rst_new", new_data, 1'b0);
    chk("rst_dig", dig_sel, 8'hFE);
    chk("rst_scan", seg_scan, 7'h40);
    rst_n = 1'b1;
    tick();
    chk("static_dig", dig_sel, 8'h00);
    chk("static_scan", seg_scan, 7'h7F);

    // update latency and flash length
    load(32'h12345678);
    chk("lat_edgeN", seg_static, e_zero);
    cnt = int'(new_data);
    tick();
    chk("upd_all", seg_static, e_ir);
    chk("upd_d1", dsg(seg_static, 1), 7'h79);
    chk("upd_d0", dsg(seg_static, 0), 7'h24);
    chk("upd_d7", dsg(seg_static, 7), 7'h78);
    chk("upd_d6", dsg(seg_static, 6), 7'h00);
    cnt += int'(new_data);
    for (int i = 0; i < 14; i++) begin
      tick();
      cnt += int'(new_data);
    end
    chk("flash_len", cnt, 10);
    chk("flash_end", new_data, 1'b0);

    // hold drops the strobe entirely
    hold = 1'b1;
    load(32'hFFFFFFFF);
    tick(); tick();
    chk("hold_static", seg_static, e_ir);
    chk("hold_new", new_data, 1'b0);
    hold = 1'b0;
    tick();
    chk("hold_nodelay", seg_static, e_ir);

    // leading-zero blanking
    blank_lz = 1'b1;
    load(32'h000000A0);
    tick();
    chk("lz_lin", seg_static_lin, {{6{7'h7F}}, 7'h08, 7'h40});
    chk("lz_ir", seg_static, {7'h08, {7{7'h40}}});
    load(32'h00000000);
    tick();
    chk("lz_zero_lin", seg_static_lin, {{7{7'h7F}}, 7'h40});
    chk("lz_zero_ir", seg_static, {{7{7'h7F}}, 7'h40});
    load(32'h00305000);
    tick();
    chk("lz_mid", seg_static_lin, {7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12, 7'h40, 7'h40, 7'h40});
    blank_lz = 1'b0;
    tick();
    chk("lz_off", seg_static_lin, {7'h40, 7'h40, 7'h30, 7'h40, 7'h12, 7'h40, 7'h40, 7'h40});

    // scan mode
    load(32'h12345678);
    tick();
    scan_mode = 1'b1;
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        exp_sel = ~(8'h01 << (s % 8));
        chk($sformatf("scan_sel_s%0d_c%0d", s, c), dig_sel, exp_sel);
        chk($sformatf("scan_seg_s%0d_c%0d", s, c), seg_scan, dsg(e_ir, s % 8));
      end
    end
    tick(); tick();
    chk("scan_pre_toggle", dig_sel, 8'hFB);
    scan_mode = 1'b0;
    tick();
    chk("toggle_off_dig", dig_sel, 8'h00);
    chk("toggle_off_seg", seg_scan, 7'h7F);
    scan_mode = 1'b1;
    tick();
    chk("toggle_on_dig", dig_sel, 8'hFE);
    chk("toggle_on_seg", seg_scan, GLY[2]);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("toggle_hold_c%0d", c), dig_sel, 8'hFE);
    end
    tick();
    chk("toggle_step", dig_sel, 8'hFD);
    chk("toggle_step_seg", seg_scan, GLY[1]);

    // flash retrigger
    chk("pre_flash", new_data, 1'b0);
    load(32'h12345678);
    for (int i = 0; i < 4; i++) tick();
    chk("flash_mid", new_data, 1'b1);
    load(32'h12345678);
    cnt = int'(new_data);
    for (int i = 0; i < 14; i++) begin
      tick();
      cnt += int'(new_data);
    end
    chk("retrig_len", cnt, 10);

    // reset aborts a running flash
    load(32'h12345678);
    tick(); tick();
    chk("flash_before_rst", new_data, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rst_flash_new", new_data, 1'b0);
    chk("rst_flash_static", seg_static, e_zero);
    chk("rst_flash_dig", dig_sel, 8'hFE);
    chk("rst_flash_scan", seg_scan, 7'h40);
    rst_n = 1'b1;
    tick();
    chk("post_rst_new", new_data, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
